layer0_lut_loader: RTL and testbench

LAYER0_LUT_LOADER -- requirements
Module: layer0_lut_loader

---
 rtl/layer0_lut_loader.sv | 160 ++++++++++++++++
 tb/tb_layer0_lut_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_lut_loader.sv
// Beat-wise loader and single-cycle lookup for one layer-0 neuron truth table.
// Optional per-beat even parity checking is enabled by defining LUT_LOADER_PARITY_EN.
module layer0_lut_loader #(
  parameter int BEAT_W   = 8,
  parameter int LUT_IN_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic                cfg_start,
  input  logic [BEAT_W-1:0]   cfg_data,
`ifdef LUT_LOADER_PARITY_EN
  input  logic                cfg_par,
`endif
  output logic                cfg_ready,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                in_valid,
  input  logic [LUT_IN_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic                out_data,
  input  logic                out_ready
);

  localparam int DEPTH   = 2 ** LUT_IN_W;
  localparam int NBEATS  = (DEPTH > BEAT_W) ? (DEPTH / BEAT_W) : 1;
  localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BEAT_SH = $clog2(BEAT_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                loaded_q, loaded_d;
  logic                cfg_err_q, cfg_err_d;
  logic                out_valid_q, out_valid_d;
  logic                out_data_q, out_data_d;
  logic [DEPTH-1:0]    table_q, table_d;

  logic                cfg_acc_s;
  logic                in_acc_s;
  logic                par_bad_s;
  logic                err_next_s;
  logic                wr_en_s;
  logic                last_s;
  logic [LUT_IN_W-1:0] base_s;

`ifdef LUT_LOADER_PARITY_EN
  function automatic logic parity_bad(input logic [BEAT_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign par_bad_s = parity_bad(cfg_data, cfg_par);
  assign cfg_err   = cfg_err_q;
`else
  assign par_bad_s = 1'b0;
  assign cfg_err   = 1'b0;
`endif

  // Holding a result blocks config so the table cannot change under a pending lookup.
  assign cfg_ready = !out_valid_q;
  assign cfg_acc_s = cfg_valid && cfg_ready;
  assign in_ready  = (state_q == ST_READY) && loaded_q && !cfg_valid &&
                     (!out_valid_q || out_ready);
  assign in_acc_s  = in_valid && in_ready;

  assign loaded    = loaded_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Load sequencing, table writes and error tracking.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    table_d    = table_q;
    err_next_s = cfg_err_q;
    wr_en_s    = 1'b0;
    last_s     = 1'b0;
    base_s     = LUT_IN_W'(cnt_q) << BEAT_SH;

    if (cfg_acc_s && cfg_start) begin
      wr_en_s    = 1'b1;
      base_s     = '0;
      err_next_s = par_bad_s;
      last_s     = (LAST_CNT == '0);
      state_d    = ST_LOAD;
      cnt_d      = CNT_W'(1);
      loaded_d   = 1'b0;
    end else if (cfg_acc_s && (state_q == ST_LOAD)) begin
      wr_en_s    = 1'b1;
      err_next_s = cfg_err_q | par_bad_s;
      last_s     = (cnt_q == LAST_CNT);
      cnt_d      = cnt_q + CNT_W'(1);
    end else begin
      wr_en_s    = 1'b0;
    end

    if (last_s) begin
      state_d  = err_next_s ? ST_EMPTY : ST_READY;
      cnt_d    = '0;
      loaded_d = !err_next_s;
    end else begin
      last_s   = 1'b0;
    end

    if (wr_en_s) begin
      table_d[base_s +: BEAT_W] = cfg_data;
    end else begin
      table_d = table_q;
    end

    cfg_err_d = err_next_s;
  end

  // Lookup result register: capture on accept, release on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_acc_s) begin
      out_valid_d = 1'b1;
      out_data_d  = table_q[in_data];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Truth-table storage; contents are meaningless until a load completes.
  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

endmodule

// File: tb/tb_layer0_lut_loader.sv
// Directed + randomized bench for layer0_lut_loader against a table-level reference model.
module tb_layer0_lut_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_start;
  logic [7:0] cfg_data;
`ifdef LUT_LOADER_PARITY_EN
  logic       cfg_par;
`endif
  logic       cfg_ready;
  logic       cfg_err;
  logic       loaded;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_data;
  logic       out_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: table contents, load progress (-1 = idle), error and loaded flags.
  bit tbl [64];
  int bidx    = -1;
  bit merr    = 1'b0;
  bit mloaded = 1'b0;

  layer0_lut_loader #(.BEAT_W(8), .LUT_IN_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
`ifdef LUT_LOADER_PARITY_EN
    .cfg_par   (cfg_par),
`endif
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input bit st, input logic [7:0] d, input bit bad);
    if (st) begin
      bidx    = 0;
      merr    = bad;
      mloaded = 1'b0;
    end else if (bidx >= 0) begin
      merr = merr | bad;
    end
    if (bidx >= 0) begin
      for (int k = 0; k < 8; k++) tbl[bidx*8 + k] = d[k];
      bidx++;
      if (bidx == 8) begin
        mloaded = !merr;
        bidx    = -1;
      end
    end
  endtask

  task automatic send_beat(input bit st, input logic [7:0] d, input bit bad);
    cfg_valid = 1'b1;
    cfg_start = st;
    cfg_data  = d;
`ifdef LUT_LOADER_PARITY_EN
    cfg_par   = (^d) ^ bad;
`endif
    #1;
    chk("cfg_ready", cfg_ready, 1'b1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    model_beat(st, d, bad);
    chk("loaded", loaded, mloaded);
    chk("cfg_err", cfg_err, merr);
  endtask

  task automatic load_rand();
    send_beat(1'b1, 8'($urandom), 1'b0);
    for (int b = 1; b < 8; b++) send_beat(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic do_lookup(input logic [5:0] a);
    in_valid = 1'b1;
    in_data  = a;
    #1;
    chk("in_ready", in_ready, mloaded);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lookup_valid", out_valid, mloaded);
    if (mloaded) begin
      chk("lookup_data", out_data, tbl[a]);
      @(posedge clk); #1;
      chk("lookup_drain", out_valid, 1'b0);
    end
  endtask

  task automatic stream(input bit toggle);
    int   nxt = 0;
    int   got = 0;
    int   cyc = 0;
    bit   exp_q[$];
    bit   stalled = 1'b0;
    logic prev = 1'b0;
    while (got < 64 && cyc < 400) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      in_valid  = (nxt < 64);
      in_data   = 6'(nxt);
      #1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev);
      end
      if (out_valid && out_ready) begin
        chk("no_extra", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) chk("stream_data", out_data, exp_q.pop_front());
        got++;
      end
      stalled = out_valid && !out_ready;
      prev    = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(tbl[nxt]);
        nxt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, 32'd64);
    chk("stream_left", exp_q.size(), 32'd0);
    if (!toggle) chk("stream_cycles", cyc, 32'd65);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    cfg_data  = 8'h00;
`ifdef LUT_LOADER_PARITY_EN
    cfg_par   = 1'b0;
`endif
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_loaded", loaded, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lookup before any load is blocked.
    do_lookup(6'd3);
    chk("empty_loaded", loaded, 1'b0);

    // Alternating-bit table.
    for (int b = 0; b < 8; b++) send_beat(b == 0, 8'hAA, 1'b0);
    chk("aa_loaded", loaded, 1'b1);
    do_lookup(6'd5);
    chk("aa_addr5", tbl[5], 1'b1);
    do_lookup(6'd4);

    // Non-start beat while READY must be ignored.
    send_beat(1'b0, 8'h55, 1'b0);
    do_lookup(6'd4);
    do_lookup(6'd1);

    // Random table, stalled then full-rate streaming.
    load_rand();
    stream(1'b1);
    stream(1'b0);

    // Abandoned partial load followed by an all-zero table.
    send_beat(1'b1, 8'($urandom), 1'b0);
    for (int b = 1; b < 4; b++) send_beat(1'b0, 8'($urandom), 1'b0);
    chk("partial_loaded", loaded, 1'b0);
    do_lookup(6'($urandom));
    for (int b = 0; b < 8; b++) send_beat(b == 0, 8'h00, 1'b0);
    stream(1'b0);

    // Config beat colliding with a lookup request takes priority.
    begin
      logic [7:0] d;
      d = 8'($urandom);
      cfg_valid = 1'b1;
      cfg_start = 1'b1;
      cfg_data  = d;
`ifdef LUT_LOADER_PARITY_EN
      cfg_par   = ^d;
`endif
      in_valid  = 1'b1;
      in_data   = 6'($urandom);
      #1;
      chk("collide_in_ready", in_ready, 1'b0);
      chk("collide_cfg_ready", cfg_ready, 1'b1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
      in_valid  = 1'b0;
      model_beat(1'b1, d, 1'b0);
      chk("collide_loaded", loaded, 1'b0);
      chk("collide_out_valid", out_valid, 1'b0);
    end
    for (int b = 1; b < 8; b++) send_beat(1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 16; i++) do_lookup(6'($urandom));

    // Reset while a result is pending drops it along with the table.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pend_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_loaded", loaded, 1'b0);
    mloaded = 1'b0;
    bidx    = -1;
    merr    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_lookup(6'd0);

`ifdef LUT_LOADER_PARITY_EN
    // Corrupted third beat poisons the load; a clean load recovers.
    for (int b = 0; b < 8; b++) send_beat(b == 0, 8'($urandom), b == 2);
    chk("par_err", cfg_err, 1'b1);
    chk("par_loaded", loaded, 1'b0);
    do_lookup(6'($urandom));
    load_rand();
    chk("par_clear", cfg_err, 1'b0);
    do_lookup(6'($urandom));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
